pong_game_ctrl: RTL
===================

# pong_game_ctrl

Game-flow controller for the Pong design: sequences serve, rally, point and game-over phases; keeps both players' scores; and gates the ball datapath via run/home/direction controls. Sits beside the ball, paddle and collision blocks in the pixel-clock domain, consumes per-side goal pulses from the ball logic and a player serve button, and uses the VGA vertical sync as its frame timebase. Score and phase outputs drive LEDs and an on-screen score overlay.

## Interface
Parameters:
- WIN_SCORE, 7, points needed to win; legal 1..15
- POINT_HOLD_FRAMES, 60, frames spent in POINT before the next phase; legal 1..255
- SERVE_DELAY_FRAMES, 120, auto-serve delay in frames (used only with AUTO_SERVE_EN); legal 1..255

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vertical sync (active-low pulse)
- serve_n  in  1  serve button, active-low, asynchronous (KEY)
- goal_0  in  1  one-cycle pulse: ball left the field past player 0
- goal_1  in  1  one-cycle pulse: ball left the field past player 1
- ball_run  out  1  1 = ball may move
- ball_home  out  1  1 = ball held at field centre
- serve_dir  out  1  0 = serve toward player 0, 1 = toward player 1
- score0  out  4  player 0 score
- score1  out  4  player 1 score
- phase  out  2  0 SERVE, 1 PLAY, 2 POINT, 3 OVER
- winner  out  2  00 none, 01 player 0, 10 player 1

## Operation
- serve_n passes through a 2-flop synchronizer; serve_press is a one-cycle pulse on the synchronized 1→0 edge.
- frame_tick: one-cycle pulse on the registered vsync 1→0 edge; 8-bit frame counter counts ticks and clears on every state entry.
- SERVE: ball_home=1, ball_run=0. serve_press → PLAY.
- PLAY: ball_home=0, ball_run=1. goal_0 → score1+1, serve_dir←0, POINT. goal_1 → score0+1, serve_dir←1, POINT. Both goals in the same cycle: goal_0 takes priority and goal_1 is dropped.
- POINT: ball_run=0, ball_home=1. After POINT_HOLD_FRAMES ticks: if either score == WIN_SCORE → OVER, with winner set; else → SERVE.
- OVER: ball_run=0, ball_home=1, scores frozen. serve_press → scores cleared, winner=00, serve_dir unchanged, SERVE.
- Goal pulses outside PLAY are ignored. serve_press outside SERVE/OVER is ignored.
- Scores saturate at WIN_SCORE and never wrap.
- Outputs are registered: Moore decode of the state register.

## Timing
- Reset values: phase=SERVE, ball_home=1, ball_run=0, serve_dir=0, score0=score1=0, winner=00, frame counter=0, synchronizer flops=1, vsync register=1.
- Reset asserted mid-game clears all state immediately, independent of clk. Deassertion is treated as synchronous to clk by the system.
- serve_n falling edge → serve_press 3 clk later (2 sync flops plus edge register) → phase/ball_run change on the following edge.
- Goal pulse in cycle N → score, serve_dir, phase=POINT and ball_run=0 all visible at N+1.
- Exit from POINT occurs on the clk edge after the POINT_HOLD_FRAMES-th frame_tick following entry.
- vsync falling edge → frame_tick 2 clk later.

## Configuration
- AUTO_SERVE_EN defined: in SERVE, leave to PLAY after SERVE_DELAY_FRAMES frame ticks even without serve_press. serve_press still serves immediately. OVER still requires serve_press.
- Not defined: SERVE waits indefinitely for serve_press, and SERVE_DELAY_FRAMES is unused.

## Test plan
- Reset, then serve_n low for 10 clk → phase 0→1, ball_run 0→1, ball_home 1→0, 4 clk after the serve_n falling edge.
- In PLAY, pulse goal_1 → next cycle score0=1, serve_dir=1, phase=2; with POINT_HOLD_FRAMES=2, phase=0 one clk after the 2nd vsync falling-edge tick.
- WIN_SCORE=3: three goal_0 rallies → score1=3, phase=3, winner=10; further goal pulses and frames → no change; serve press → scores 0, winner 00, phase 0.
- goal_0 and goal_1 in the same cycle during PLAY → only score1 increments; goal pulses in SERVE/POINT → scores unchanged.
- rst_n low for 1 ns mid-POINT with score0=2 → all outputs at reset values without a clk edge.
- With AUTO_SERVE_EN and SERVE_DELAY_FRAMES=3, no serve press → PLAY one clk after the 3rd frame_tick; without the macro, still in SERVE after 10 frames.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: serve/play/point/over sequencing, score keeping and ball gating.
// Optional AUTO_SERVE_EN macro: SERVE also leaves to PLAY after SERVE_DELAY_FRAMES frame ticks.
module pong_game_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int POINT_HOLD_FRAMES  = 60,
  parameter int SERVE_DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       serve_n,
  input  logic       goal_0,
  input  logic       goal_1,
  output logic       ball_run,
  output logic       ball_home,
  output logic       serve_dir,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [1:0] phase,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD  = 8'(POINT_HOLD_FRAMES);
  localparam logic [7:0] DELAY = 8'(SERVE_DELAY_FRAMES);
`ifdef AUTO_SERVE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  state_t     state, state_nxt;
  logic       serve_p0, serve_p1, serve_p2, serve_press;
  logic       vsync_p0, vsync_p1, frame_tick;
  logic [7:0] frame_cnt;
  logic [3:0] score0_nxt, score1_nxt;
  logic [1:0] winner_nxt;
  logic       dir_nxt;
  logic       hold_done, serve_timeout;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  // Input conditioning: serve button synchronizer + edge register, vsync edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serve_p0    <= 1'b1;
      serve_p1    <= 1'b1;
      serve_p2    <= 1'b1;
      serve_press <= 1'b0;
      vsync_p0    <= 1'b1;
      vsync_p1    <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      serve_p0    <= serve_n;
      serve_p1    <= serve_p0;
      serve_p2    <= serve_p1;
      serve_press <= serve_p2 & ~serve_p1;
      vsync_p0    <= vsync;
      vsync_p1    <= vsync_p0;
      frame_tick  <= vsync_p1 & ~vsync_p0;
    end
  end

  assign hold_done     = frame_tick && (frame_cnt + 8'd1 == HOLD);
  assign serve_timeout = frame_tick && (frame_cnt + 8'd1 == DELAY);

  always_comb begin
    state_nxt  = state;
    score0_nxt = score0;
    score1_nxt = score1;
    winner_nxt = winner;
    dir_nxt    = serve_dir;
    case (state)
      ST_SERVE: begin
        if (serve_press || (AUTO_EN && serve_timeout))
          state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // goal_0 wins a simultaneous double goal
        if (goal_0) begin
          score1_nxt = sat_inc(score1);
          dir_nxt    = 1'b0;
          state_nxt  = ST_POINT;
        end else if (goal_1) begin
          score0_nxt = sat_inc(score0);
          dir_nxt    = 1'b1;
          state_nxt  = ST_POINT;
        end
      end
      ST_POINT: begin
        if (hold_done) begin
          if (score0 == WIN) begin
            winner_nxt = 2'b01;
            state_nxt  = ST_OVER;
          end else if (score1 == WIN) begin
            winner_nxt = 2'b10;
            state_nxt  = ST_OVER;
          end else begin
            state_nxt  = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (serve_press) begin
          score0_nxt = 4'd0;
          score1_nxt = 4'd0;
          winner_nxt = 2'b00;
          state_nxt  = ST_SERVE;
        end
      end
      default: state_nxt = ST_SERVE;
    endcase
  end

  // Game state register; frame counter restarts on every phase change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SERVE;
      score0    <= 4'd0;
      score1    <= 4'd0;
      winner    <= 2'b00;
      serve_dir <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      score0    <= score0_nxt;
      score1    <= score1_nxt;
      winner    <= winner_nxt;
      serve_dir <= dir_nxt;
      if (state_nxt != state)
        frame_cnt <= 8'd0;
      else if (frame_tick)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign phase     = state;
  assign ball_run  = (state == ST_PLAY);
  assign ball_home = (state != ST_PLAY);

endmodule
